// File: rtl/tdm_demux_deser_if.sv
// Bit-stream input and tagged word output bundle of the TDM demux/deserializer.
// master = environment side (mux + consumer), slave = the deserializer.
interface tdm_demux_deser_if #(
  parameter int WIDTH = 4
);
  logic             bit_in;
  logic             bit_sel;
  logic             bit_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_ch;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  modport master (
    output bit_in, bit_sel, bit_vld, out_ready,
    input  out_data, out_ch, out_valid, overflow
  );

  modport slave (
    input  bit_in, bit_sel, bit_vld, out_ready,
    output out_data, out_ch, out_valid, overflow
  );
endinterface

// File: rtl/tdm_demux_deser.sv
// Demultiplexes a 2-channel serial bit stream into per-channel LSB-first words,
// buffers one completed word per channel and presents them round-robin on a
// single valid/ready port tagged with the channel id.
module tdm_demux_deser #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tdm_demux_deser_if.slave        bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  logic [WIDTH-1:0] sh       [2];
  logic [CNT_W-1:0] cnt      [2];
  logic [WIDTH-1:0] hold     [2];
  logic [1:0]       hold_full;

  logic [WIDTH-1:0] out_data_q;
  logic             out_ch_q;
  logic             out_valid_q;
  logic             overflow_q;

  ch_e              last_q;
  ch_e              last_d;

  logic             slot_free;
  logic             load;
  logic             pick;
  logic [1:0]       complete;
  logic [1:0]       move;
  logic [WIDTH-1:0] new_word;

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;

  // Completion detect, output-slot arbitration and round-robin pointer next state
  always_comb begin
    new_word  = {bus.bit_in, sh[bus.bit_sel][WIDTH-1:1]};
    slot_free = !out_valid_q || bus.out_ready;
    load      = slot_free && (|hold_full);
    pick      = 1'b0;
    if (hold_full == 2'b11) begin
      pick = (last_q == CH0) ? 1'b1 : 1'b0;
    end else if (hold_full[1]) begin
      pick = 1'b1;
    end
    last_d = load ? ch_e'(pick) : last_q;
    for (int unsigned c = 0; c < 2; c++) begin
      complete[c] = bus.bit_vld && (bus.bit_sel == 1'(c)) &&
                    (cnt[c] == CNT_W'(WIDTH - 1));
      move[c]     = load && (pick == 1'(c));
    end
  end

  // Per-channel shift/count and hold buffer; a word completing while its hold
  // is still occupied (and not leaving this cycle) is dropped and flagged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < 2; c++) begin
        sh[c]   <= '0;
        cnt[c]  <= '0;
        hold[c] <= '0;
      end
      hold_full  <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (bus.bit_vld && (bus.bit_sel == 1'(c))) begin
          sh[c]  <= new_word;
          cnt[c] <= complete[c] ? '0 : cnt[c] + 1'b1;
        end
        if (complete[c]) begin
          if (!hold_full[c] || move[c]) begin
            hold[c]      <= new_word;
            hold_full[c] <= 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end else if (move[c]) begin
          hold_full[c] <= 1'b0;
        end
      end
    end
  end

  // Output register stage and round-robin pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= CH1;
    end else begin
      last_q <= last_d;
      if (slot_free) begin
        if (load) begin
          out_data_q  <= hold[pick];
          out_ch_q    <= pick;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_deser.sv
// Directed testbench for tdm_demux_deser (WIDTH=4).
module tb_tdm_demux_deser;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  tdm_demux_deser_if #(.WIDTH(4)) bus ();

  tdm_demux_deser #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are observed 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic sel, input logic b);
    bus.bit_vld = 1'b1;
    bus.bit_sel = sel;
    bus.bit_in  = b;
    tick();
    bus.bit_vld = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic ch);
    chk({tag, "_valid"}, 8'(bus.out_valid), 8'(v));
    chk({tag, "_data"},  8'(bus.out_data),  8'(d));
    chk({tag, "_ch"},    8'(bus.out_ch),    8'(ch));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_sel   = 1'b0;
    bus.bit_vld   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 4'h0, 1'b0);
    chk("reset_ovf", 8'(bus.overflow), 8'd0);
    rst_n = 1'b1;

    // 1: ch0 bits 1,0,1,1 -> 4'b1101 one cycle after the last bit
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("t1_lat_valid", 8'(bus.out_valid), 8'd0);
    tick();
    chk_out("t1_word", 1'b1, 4'hD, 1'b0);
    chk("t1_ovf", 8'(bus.overflow), 8'd0);
    tick();
    chk("t1_drained", 8'(bus.out_valid), 8'd0);

    // 2: interleaved ch0 1111 / ch1 0101 -> F ch0 then A ch1 back to back
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    chk_out("t2_w0", 1'b1, 4'hF, 1'b0);
    tick();
    chk_out("t2_w1", 1'b1, 4'hA, 1'b1);
    tick();
    chk("t2_drained", 8'(bus.out_valid), 8'd0);

    // 3: ch0 1010 (5) and ch1 1100 (3) with consumer stalled for 10 cycles
    bus.out_ready = 1'b0;
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk_out("t3_first", 1'b1, 4'h5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("t3_stall", 1'b1, 4'h5, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk_out("t3_second", 1'b1, 4'h3, 1'b1);
    tick();
    chk("t3_drained", 8'(bus.out_valid), 8'd0);
    chk("t3_ovf", 8'(bus.overflow), 8'd0);

    // 4: stalled consumer, ch0 words 1,2,3 -> 3 dropped, overflow sticky
    bus.out_ready = 1'b0;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t4_no_ovf_yet", 8'(bus.overflow), 8'd0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t4_ovf", 8'(bus.overflow), 8'd1);
    chk_out("t4_out1", 1'b1, 4'h1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk_out("t4_out2", 1'b1, 4'h2, 1'b0);
    tick();
    chk("t4_drained", 8'(bus.out_valid), 8'd0);
    tick();
    chk("t4_ovf_sticky", 8'(bus.overflow), 8'd1);

    // 5: reset with ch0 word pending and 2 ch1 bits partially assembled
    bus.out_ready = 1'b0;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    tick();
    chk_out("t5_pending", 1'b1, 4'h9, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("t5_reset", 1'b0, 4'h0, 1'b0);
    chk("t5_reset_ovf", 8'(bus.overflow), 8'd0);
    bus.out_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("t5_b1_valid", 8'(bus.out_valid), 8'd0);
    send_bit(1'b1, 1'b0);
    chk("t5_b2_valid", 8'(bus.out_valid), 8'd0);
    send_bit(1'b1, 1'b1);
    chk("t5_b3_valid", 8'(bus.out_valid), 8'd0);
    send_bit(1'b1, 1'b0);
    chk("t5_b4_valid", 8'(bus.out_valid), 8'd0);
    tick();
    chk_out("t5_word", 1'b1, 4'h4, 1'b1);
    tick();
    chk("t5_only_one", 8'(bus.out_valid), 8'd0);
    tick();
    chk("t5_still_none", 8'(bus.out_valid), 8'd0);

    // 6: ch0 1,0,0,1 with bit_vld gaps -> 4'b1001
    send_bit(1'b0, 1'b1);
    tick();
    send_bit(1'b0, 1'b0);
    tick();
    tick();
    send_bit(1'b0, 1'b0);
    bus.bit_in = 1'b1;
    tick();
    send_bit(1'b0, 1'b1);
    chk("t6_lat_valid", 8'(bus.out_valid), 8'd0);
    tick();
    chk_out("t6_word", 1'b1, 4'h9, 1'b0);
    chk("t6_ovf", 8'(bus.overflow), 8'd0);
    tick();
    chk("t6_drained", 8'(bus.out_valid), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
